// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - shared state encoding, address map and default ID words for the system ID checker
package sysid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_FIN   = 2'd3
    } sysid_state_t;

    localparam logic        ID_ADDR    = 1'b0;
    localparam logic        TS_ADDR    = 1'b1;

    localparam logic [31:0] DEF_EXP_ID = 32'd611894095;
    localparam logic [31:0] DEF_EXP_TS = 32'd1554360052;

endpackage

// File: rtl/sysid_wdog.sv
// rtl/sysid_wdog.sv - saturating 8-bit stall counter that flags a read timeout
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, clears the count
//   clr      synchronous clear (entry into a read state), wins over inc
//   inc      one stall cycle observed this cycle
//   limit    stall cycles allowed per read (1..255)
//   expired  this stall cycle is the limit-th one of the current read
module sysid_wdog (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;
    logic [7:0] count_inc;

    // Saturate at limit so a long stall can never wrap back to zero.
    assign count_inc = (count == limit) ? count : count + 8'd1;

    // Count including the current stall cycle; the read is abandoned on the
    // limit-th stall so avm_read is high for exactly limit stalled cycles.
    assign expired = inc && (count_inc == limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/sysid_checker.sv
// rtl/sysid_checker.sv - reads system ID and timestamp words over Avalon-MM and compares them to expected values
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 single-cycle check request (ignored while busy)
//   avm_address/avm_read  master word address (0 = ID, 1 = timestamp) and read strobe
//   avm_readdata          read data, valid when avm_read=1 and avm_waitrequest=0
//   avm_waitrequest       slave stall
//   busy, done            check in progress, one-cycle completion pulse
//   id_match, ts_match    captured words equal EXP_ID / EXP_TS (valid with done)
//   timeout_err           last check aborted on a stalled read
//   id_value, ts_value    last captured words
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXP_ID         = DEF_EXP_ID,
    parameter logic [31:0] EXP_TS         = DEF_EXP_TS,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_match,
    output logic        ts_match,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    sysid_state_t state;
    sysid_state_t state_nxt;
    logic         auto_pend;
    logic         trigger;
    logic         wd_clr;
    logic         wd_inc;
    logic         expired;

    // auto_pend is high only in the first cycle after reset release, so an
    // external start in that cycle simply ORs into the same single check.
    assign trigger = start || auto_pend;

    sysid_wdog u_wdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wd_clr),
        .inc     (wd_inc),
        .limit   (TO_LIMIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        avm_read    = 1'b0;
        avm_address = ID_ADDR;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_nxt = ST_RD_ID;
                    wd_clr    = 1'b1;
                end
            end
            ST_RD_ID: begin
                avm_read    = 1'b1;
                avm_address = ID_ADDR;
                if (!avm_waitrequest) begin
                    state_nxt = ST_RD_TS;
                    wd_clr    = 1'b1;
                end else begin
                    wd_inc = 1'b1;
                    if (expired) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_RD_TS: begin
                avm_read    = 1'b1;
                avm_address = TS_ADDR;
                if (!avm_waitrequest) begin
                    state_nxt = ST_FIN;
                end else begin
                    wd_inc = 1'b1;
                    if (expired) begin
                        state_nxt = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    // Results are cleared when a check launches. The match flags are written
    // on the edge into FIN so they are already valid alongside the done pulse;
    // a timed-out check never reaches that write and leaves them at 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_pend   <= AUTO_START;
            id_match    <= 1'b0;
            ts_match    <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            auto_pend <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        id_match    <= 1'b0;
                        ts_match    <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value <= avm_readdata;
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                    end
                end
                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value <= avm_readdata;
                        id_match <= (id_value == EXP_ID);
                        ts_match <= (avm_readdata == EXP_TS);
                    end else if (expired) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// tb/tb_sysid_checker.sv - directed self-checking bench for sysid_checker
module tb_sysid_checker;

    localparam logic [31:0] ID_OK = 32'd611894095;
    localparam logic [31:0] TS_OK = 32'd1554360052;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        id_match;
    logic        ts_match;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    logic [31:0] id_word = ID_OK;
    logic [31:0] ts_word = TS_OK;
    int          stall_cfg = 0;
    int          stall_cnt = 0;

    int n_checks = 0;
    int n_errors = 0;
    int first_done;
    int n_done;

    always #5 clk = ~clk;

    sysid_checker #(
        .TIMEOUT_CYCLES (4),
        .AUTO_START     (1'b1)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .id_match        (id_match),
        .ts_match        (ts_match),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
    );

    // Slave model: stalls each read for stall_cfg cycles, then returns the word.
    assign avm_readdata    = avm_address ? ts_word : id_word;
    assign avm_waitrequest = avm_read && (stall_cnt < stall_cfg);

    always @(posedge clk) begin
        if (!avm_read || !avm_waitrequest) begin
            stall_cnt <= 0;
        end else begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; optionally pulses start, optionally injects a
    // second start in cycle inj, and watches done for window cycles.
    task automatic run_check(input bit pulse, input int inj, input int window,
                             output int fd, output int nd);
        fd = -1;
        nd = 0;
        start = pulse;
        for (int c = 1; c <= window; c++) begin
            @(negedge clk);
            start = (c == inj);
            if (done) begin
                nd++;
                if (fd < 0) fd = c;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_idv", id_value, 32'd0);
        check("rst_tsv", ts_value, 32'd0);
        check("rst_flags", {29'd0, id_match, ts_match, timeout_err}, 32'd0);

        // Auto-start after release
        reset_n = 1'b1;
        run_check(1'b0, 0, 6, first_done, n_done);
        check("auto_lat", 32'(first_done), 32'd3);
        check("auto_ndone", 32'(n_done), 32'd1);
        check("auto_idm", 32'(id_match), 32'd1);
        check("auto_tsm", 32'(ts_match), 32'd1);

        // Zero-wait check, cycle by cycle
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("c1_read", 32'(avm_read), 32'd1);
        check("c1_addr", 32'(avm_address), 32'd0);
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_done", 32'(done), 32'd0);
        @(negedge clk);
        check("c2_read", 32'(avm_read), 32'd1);
        check("c2_addr", 32'(avm_address), 32'd1);
        @(negedge clk);
        check("c3_done", 32'(done), 32'd1);
        check("c3_read", 32'(avm_read), 32'd0);
        check("c3_addr", 32'(avm_address), 32'd0);
        check("c3_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("c4_done", 32'(done), 32'd0);
        check("c4_busy", 32'(busy), 32'd0);
        check("zw_idm", 32'(id_match), 32'd1);
        check("zw_tsm", 32'(ts_match), 32'd1);
        check("zw_to", 32'(timeout_err), 32'd0);
        check("zw_idv", id_value, ID_OK);
        check("zw_tsv", ts_value, TS_OK);

        // Wrong ID word
        id_word = 32'h0000_0000;
        run_check(1'b1, 0, 6, first_done, n_done);
        check("bad_lat", 32'(first_done), 32'd3);
        check("bad_idm", 32'(id_match), 32'd0);
        check("bad_tsm", 32'(ts_match), 32'd1);
        check("bad_idv", id_value, 32'd0);
        check("bad_to", 32'(timeout_err), 32'd0);

        // Three stall cycles per read
        id_word   = ID_OK;
        stall_cfg = 3;
        run_check(1'b1, 0, 12, first_done, n_done);
        check("st3_lat", 32'(first_done), 32'd9);
        check("st3_idm", 32'(id_match), 32'd1);
        check("st3_tsm", 32'(ts_match), 32'd1);
        check("st3_to", 32'(timeout_err), 32'd0);

        // Stuck slave, limit 4: read high for 4 stalled cycles then FIN
        stall_cfg = 1000;
        id_word   = 32'h1234_5678;
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            check($sformatf("to_read_c%0d", c), 32'(avm_read), 32'd1);
        end
        @(negedge clk);
        check("to_read_c5", 32'(avm_read), 32'd0);
        check("to_done_c5", 32'(done), 32'd1);
        @(negedge clk);
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_idm", 32'(id_match), 32'd0);
        check("to_tsm", 32'(ts_match), 32'd0);
        check("to_idv", id_value, ID_OK);
        check("to_tsv", ts_value, TS_OK);

        // start during RD_TS is dropped
        stall_cfg = 0;
        id_word   = ID_OK;
        run_check(1'b1, 2, 8, first_done, n_done);
        check("ign_lat", 32'(first_done), 32'd3);
        check("ign_ndone", 32'(n_done), 32'd1);
        check("ign_to", 32'(timeout_err), 32'd0);
        check("ign_busy", 32'(busy), 32'd0);

        // Reset in RD_ID, then auto restart
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mr_read_pre", 32'(avm_read), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("mr_busy", 32'(busy), 32'd0);
        check("mr_read", 32'(avm_read), 32'd0);
        check("mr_done", 32'(done), 32'd0);
        check("mr_idv", id_value, 32'd0);
        check("mr_tsv", ts_value, 32'd0);
        check("mr_flags", {29'd0, id_match, ts_match, timeout_err}, 32'd0);
        @(negedge clk);
        check("mr_done_held", 32'(done), 32'd0);
        reset_n = 1'b1;
        run_check(1'b0, 0, 6, first_done, n_done);
        check("mr_lat", 32'(first_done), 32'd3);
        check("mr_ndone", 32'(n_done), 32'd1);
        check("mr_idm", 32'(id_match), 32'd1);
        check("mr_idv2", id_value, ID_OK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sysid_checker.md
SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 SHALL have parameter EXP_ID, default 611894095, expected 32-bit system ID word at address 0.
REQ-002 SHALL have parameter EXP_TS, default 1554360052, expected 32-bit timestamp word at address 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, range 1..255, maximum waitrequest cycles per read.
REQ-004 SHALL have parameter AUTO_START, default 1, where 1 starts one check automatically after reset release.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1, single-cycle request to run a check.
REQ-008 SHALL have port avm_address, output, 1, Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-009 SHALL have port avm_read, output, 1, Avalon-MM read strobe.
REQ-010 SHALL have port avm_readdata, input, 32, read data, valid in any cycle with avm_read=1 and avm_waitrequest=0.
REQ-011 SHALL have port avm_waitrequest, input, 1, slave stall; tie to 0 for a zero-wait slave.
REQ-012 SHALL have port busy, output, 1, check in progress.
REQ-013 SHALL have port done, output, 1, one-cycle pulse when a check finishes.
REQ-014 SHALL have port id_match, output, 1, captured ID equals EXP_ID.
REQ-015 SHALL have port ts_match, output, 1, captured timestamp equals EXP_TS.
REQ-016 SHALL have port timeout_err, output, 1, last check aborted on timeout.
REQ-017 SHALL have port id_value, output, 32, last captured ID word.
REQ-018 SHALL have port ts_value, output, 32, last captured timestamp word.

Function
REQ-019 SHALL implement FSM states IDLE, RD_ID, RD_TS, FIN.
REQ-020 IDLE: start=1 (or the AUTO_START trigger) SHALL move to RD_ID next cycle and clear id_match, ts_match and timeout_err in that same edge.
REQ-021 RD_ID: SHALL drive avm_read=1 and avm_address=0; on avm_waitrequest=0, SHALL capture avm_readdata into id_value and go to RD_TS.
REQ-022 RD_TS: SHALL drive avm_read=1 and avm_address=1; on avm_waitrequest=0, SHALL capture avm_readdata into ts_value and go to FIN.
REQ-023 With a zero-wait slave, start-to-done latency SHALL be exactly 3 cycles (RD_ID, RD_TS, FIN).
REQ-024 FIN: SHALL pulse done=1 for one cycle, set id_match=(id_value==EXP_ID) and ts_match=(ts_value==EXP_TS) unless timeout_err=1, then return to IDLE.
REQ-025 In IDLE and FIN, avm_read SHALL be 0 and avm_address SHALL be 0.
REQ-026 An 8-bit wait counter SHALL clear on entry to each read state and increment each cycle with avm_waitrequest=1.
REQ-027 When the wait counter equals TIMEOUT_CYCLES with avm_waitrequest=1, the FSM SHALL deassert avm_read next cycle, set timeout_err=1, leave id_match and ts_match at 0, keep the last id_value/ts_value, and go to FIN.
REQ-028 The wait counter SHALL saturate at TIMEOUT_CYCLES and never wrap.
REQ-029 start while busy=1 SHALL be ignored and not queued.
REQ-030 busy SHALL be 1 exactly in RD_ID, RD_TS and FIN.
REQ-031 id_match, ts_match, timeout_err, id_value and ts_value SHALL hold until the next check starts.
REQ-032 With AUTO_START=1, exactly one check SHALL start in the first cycle after reset_n deasserts; a simultaneous start pulse SHALL merge with it and not cause a second check.

Reset
REQ-033 reset_n=0 SHALL asynchronously force state IDLE, wait counter 0, avm_read=0, avm_address=0, busy=0, done=0, id_match=0, ts_match=0, timeout_err=0, id_value=0, ts_value=0.
REQ-034 Reset mid-read SHALL abort the transaction with no done pulse; with AUTO_START=1, the check restarts after release.

Structure
REQ-035 A shared package sysid_pkg SHALL hold the FSM state encoding, the address constants ID_ADDR=0 and TS_ADDR=1, and the default EXP_ID/EXP_TS values.
REQ-036 The wait counter SHALL be a sub-module named sysid_wdog with ports clk, reset_n, clr, inc, limit and expired.

Verification
REQ-037 Zero-wait slave returning 611894095 then 1554360052, start pulsed -> done at cycle 3, id_match=1, ts_match=1, timeout_err=0.
REQ-038 Slave returning 0x00000000 for the ID -> done, id_match=0, ts_match=1, id_value=0.
REQ-039 avm_waitrequest=1 for 3 cycles on each read -> done at cycle 9, both matches=1, no timeout.
REQ-040 avm_waitrequest stuck at 1, TIMEOUT_CYCLES=4 -> avm_read drops after the 4th stall cycle, timeout_err=1, done pulses, matches=0.
REQ-041 start pulsed during RD_TS -> only one done pulse, no second check.
REQ-042 reset_n asserted during RD_ID with AUTO_START=1 -> all outputs 0 immediately; a new check completes 3 cycles after release.
